nw_fill_sequencer: RTL

//  Sequences the Needleman-Wunsch matrix-fill phase cell by cell, in row-major order over i=1..N, j=1..M.
//  For each cell it runs one loop: request the three neighbour scores and the residues, wait for the data,

---
 rtl/nw_pkg.sv | 24 ++
 rtl/nw_idx_counter.sv | 42 ++++
 rtl/nw_fill_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch fill datapath: state encoding
// (also used by debug probes), index-width helper and default geometry.
package nw_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] READ    = 3'd1;
   localparam logic [2:0] WAIT_RD = 3'd2;
   localparam logic [2:0] CALC    = 3'd3;
   localparam logic [2:0] WRITE   = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   // Smallest width able to hold the value len (indices run 1..len).
   function automatic int idx_width(input int len);
      int w;
      w = 1;
      while ((1 << w) <= len) w = w + 1;
      return w;
   endfunction

   localparam int N_DEF  = 8;
   localparam int M_DEF  = 8;
   localparam int IW_DEF = idx_width((N_DEF > M_DEF) ? N_DEF : M_DEF);

endpackage

// File: rtl/nw_idx_counter.sv
// Row-major 2-D cell counter: j wraps at m_lim and carries into i.
// clr has priority over load, load over step.
module nw_idx_counter
   import nw_pkg::*;
#(
   parameter int IW = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic          step,
   input  logic [IW-1:0] n_lim,
   input  logic [IW-1:0] m_lim,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic          last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i <= '0;
         j <= '0;
      end else if (clr) begin
         i <= '0;
         j <= '0;
      end else if (load) begin
         i <= IW'(1);
         j <= IW'(1);
      end else if (step) begin
         if (j == m_lim) begin
            j <= IW'(1);
            i <= i + IW'(1);
         end else begin
            j <= j + IW'(1);
         end
      end
   end

   assign last = (i == n_lim) && (j == m_lim);

endmodule

// File: rtl/nw_fill_sequencer.sv
// Matrix-fill sequencer: walks every cell through read / wait / score / write
// and pulses end_fill once the last cell has been written.
//
// state   | meaning
// IDLE    | waiting for start, indices 0
// READ    | one-cycle read request for the current cell
// WAIT_RD | waiting for neighbour/residue data (rd_valid)
// CALC    | scoring PE busy, calc_req held until calc_ack
// WRITE   | one-cycle write strobe, then advance or finish
// DONE    | end_fill pulse, indices hold the last cell
module nw_fill_sequencer
   import nw_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int M  = M_DEF,
   parameter int IW = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          rd_valid,
   input  logic          calc_ack,
   output logic [IW-1:0] i_idx,
   output logic [IW-1:0] j_idx,
   output logic          rd_en,
   output logic          calc_req,
   output logic          we,
   output logic          busy,
   output logic          end_fill
);

   localparam logic [IW-1:0] N_LIM = IW'(N);
   localparam logic [IW-1:0] M_LIM = IW'(M);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       last;
   logic       rd_en_d;
   logic       calc_req_d;
   logic       we_d;
   logic       busy_d;
   logic       end_fill_d;

   nw_idx_counter #(.IW(IW)) u_idx (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == DONE),
      .load  ((state == IDLE) && start),
      .step  ((state == WRITE) && !last),
      .n_lim (N_LIM),
      .m_lim (M_LIM),
      .i     (i_idx),
      .j     (j_idx),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    state_nxt = WAIT_RD;
         WAIT_RD: if (rd_valid) state_nxt = CALC;
         CALC:    if (calc_ack) state_nxt = WRITE;
         WRITE:   state_nxt = last ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each strobe
   // lines up exactly with the cycle spent in its state.
   always_comb begin
      rd_en_d    = (state_nxt == READ);
      calc_req_d = (state_nxt == CALC);
      we_d       = (state_nxt == WRITE);
      end_fill_d = (state_nxt == DONE);
      busy_d     = (state_nxt == READ) || (state_nxt == WAIT_RD) ||
                   (state_nxt == CALC) || (state_nxt == WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en    <= 1'b0;
         calc_req <= 1'b0;
         we       <= 1'b0;
         busy     <= 1'b0;
         end_fill <= 1'b0;
      end else begin
         rd_en    <= rd_en_d;
         calc_req <= calc_req_d;
         we       <= we_d;
         busy     <= busy_d;
         end_fill <= end_fill_d;
      end
   end

endmodule
